// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between an execute port (A)
// and a branch/address port (B), with a one-entry registered result slot per port.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4,
  parameter int unsigned COMP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic [OP_WIDTH-1:0]   a_op,
  input  logic [DATA_WIDTH-1:0] a_din1,
  input  logic [DATA_WIDTH-1:0] a_din2,
  output logic                  a_resp_valid,
  input  logic                  a_resp_ready,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic [COMP_WIDTH-1:0] a_comp,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic [OP_WIDTH-1:0]   b_op,
  input  logic [DATA_WIDTH-1:0] b_din1,
  input  logic [DATA_WIDTH-1:0] b_din2,
  output logic                  b_resp_valid,
  input  logic                  b_resp_ready,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic [COMP_WIDTH-1:0] b_comp,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_din1,
  output logic [DATA_WIDTH-1:0] alu_din2,
  input  logic [DATA_WIDTH-1:0] alu_dout,
  input  logic [COMP_WIDTH-1:0] alu_comp
);

  localparam logic [OP_WIDTH-1:0] ALU_OP_NOP = '0;

  logic ptr_b;  // 1: B wins the next tie, 0: A wins
  logic elig_a, elig_b;
  logic grant_a, grant_b;

  // A port may issue when its result slot is empty or draining this cycle
  always_comb begin
    elig_a  = a_req_valid && (!a_resp_valid || a_resp_ready);
    elig_b  = b_req_valid && (!b_resp_valid || b_resp_ready);
    grant_a = elig_a && (!elig_b || !ptr_b);
    grant_b = elig_b && (!elig_a || ptr_b);
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  // Operand routing to the shared ALU
  always_comb begin
    alu_op   = ALU_OP_NOP;
    alu_din1 = '0;
    alu_din2 = '0;
    if (grant_a) begin
      alu_op   = a_op;
      alu_din1 = a_din1;
      alu_din2 = a_din2;
    end else if (grant_b) begin
      alu_op   = b_op;
      alu_din1 = b_din1;
      alu_din2 = b_din2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_b <= 1'b0;
    end else if (grant_a) begin
      ptr_b <= 1'b1;
    end else if (grant_b) begin
      ptr_b <= 1'b0;
    end
  end

  // Port A result slot: capture on accept, clear on drain, data held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_resp_valid <= 1'b0;
      a_dout       <= '0;
      a_comp       <= '0;
    end else if (grant_a) begin
      a_resp_valid <= 1'b1;
      a_dout       <= alu_dout;
      a_comp       <= alu_comp;
    end else if (a_resp_valid && a_resp_ready) begin
      a_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_resp_valid <= 1'b0;
      b_dout       <= '0;
      b_comp       <= '0;
    end else if (grant_b) begin
      b_resp_valid <= 1'b1;
      b_dout       <= alu_dout;
      b_comp       <= alu_comp;
    end else if (b_resp_valid && b_resp_ready) begin
      b_resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter with a behavioural ALU stub.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                         OP_OR = 4'd4, OP_XOR = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [3:0]  a_op;
  logic [31:0] a_din1, a_din2, a_dout;
  logic [2:0]  a_comp;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [3:0]  b_op;
  logic [31:0] b_din1, b_din2, b_dout;
  logic [2:0]  b_comp;
  logic [3:0]  alu_op;
  logic [31:0] alu_din1, alu_din2, alu_dout;
  logic [2:0]  alu_comp;

  int n_total = 0;
  int n_pass  = 0;
  bit run = 1'b0;
  bit a_acc = 1'b0, b_acc = 1'b0;
  bit ptr_a = 1'b1;
  logic [34:0] qa[$], qb[$];
  req_t a_dir[$], b_dir[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .COMP_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op(a_op),
    .a_din1(a_din1), .a_din2(a_din2), .a_resp_valid(a_resp_valid),
    .a_resp_ready(a_resp_ready), .a_dout(a_dout), .a_comp(a_comp),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op(b_op),
    .b_din1(b_din1), .b_din2(b_din2), .b_resp_valid(b_resp_valid),
    .b_resp_ready(b_resp_ready), .b_dout(b_dout), .b_comp(b_comp),
    .alu_op(alu_op), .alu_din1(alu_din1), .alu_din2(alu_din2),
    .alu_dout(alu_dout), .alu_comp(alu_comp)
  );

  // Reference ALU semantics; comp = {LTU, LT (signed), EQ}
  function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
    logic [31:0] r;
    logic [2:0]  c;
    c = {x < y, $signed(x) < $signed(y), x == y};
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SLT:  r = 32'(c[1]);
      OP_SLTU: r = 32'(c[2]);
      default: r = '0;
    endcase
    return {c, r};
  endfunction

  always_comb {alu_comp, alu_dout} = alu_fn(alu_op, alu_din1, alu_din2);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic req_t next_req(input bit is_a);
    req_t r;
    if (is_a && a_dir.size() != 0) return a_dir.pop_front();
    if (!is_a && b_dir.size() != 0) return b_dir.pop_front();
    r.op = 4'($urandom_range(0, 7));
    r.x  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
    r.y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
    return r;
  endfunction

  // One cycle of stimulus; a pending request is held until accepted
  task automatic step(input bit want_a, input bit want_b, input bit rr_a, input bit rr_b);
    req_t r;
    @(negedge clk);
    if (!a_req_valid || a_acc) begin
      a_req_valid = want_a;
      if (want_a) begin r = next_req(1'b1); a_op = r.op; a_din1 = r.x; a_din2 = r.y; end
    end
    if (!b_req_valid || b_acc) begin
      b_req_valid = want_b;
      if (want_b) begin r = next_req(1'b0); b_op = r.op; b_din1 = r.x; b_din2 = r.y; end
    end
    a_resp_ready = rr_a;
    b_resp_ready = rr_b;
  endtask

  // Monitor: arbitration and ALU drive checks, then response scoreboard
  initial forever begin
    bit ea, eb, ga, gb;
    @(negedge clk);
    #1;
    if (run) begin
      ea = a_req_valid && (qa.size() == 0 || a_resp_ready);
      eb = b_req_valid && (qb.size() == 0 || b_resp_ready);
      ga = ea && (!eb || ptr_a);
      gb = eb && !ga;
      chk("a_req_ready", 64'(a_req_ready), 64'(ga));
      chk("b_req_ready", 64'(b_req_ready), 64'(gb));
      if (ga) chk("alu_drive_a", {alu_op, alu_din1, alu_din2}, {a_op, a_din1, a_din2});
      else if (gb) chk("alu_drive_b", {alu_op, alu_din1, alu_din2}, {b_op, b_din1, b_din2});
      else chk("alu_idle", {alu_op, alu_din1, alu_din2}, 68'(0));
      chk("a_resp_valid", 64'(a_resp_valid), 64'(qa.size() != 0));
      chk("b_resp_valid", 64'(b_resp_valid), 64'(qb.size() != 0));
      if (qa.size() != 0) chk("a_result", {a_comp, a_dout}, qa[0]);
      if (qb.size() != 0) chk("b_result", {b_comp, b_dout}, qb[0]);
      if (a_resp_ready && qa.size() != 0) void'(qa.pop_front());
      if (b_resp_ready && qb.size() != 0) void'(qb.pop_front());
      a_acc = a_req_valid && a_req_ready;
      b_acc = b_req_valid && b_req_ready;
      if (a_acc) qa.push_back(alu_fn(a_op, a_din1, a_din2));
      if (b_acc) qb.push_back(alu_fn(b_op, b_din1, b_din2));
      if (ga) ptr_a = 1'b0;
      else if (gb) ptr_a = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_req_valid = 0; a_op = 0; a_din1 = 0; a_din2 = 0; a_resp_ready = 0;
    b_req_valid = 0; b_op = 0; b_din1 = 0; b_din2 = 0; b_resp_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", {a_resp_valid, b_resp_valid}, 64'(0));
    chk("rst_data", {a_comp, a_dout, b_comp, b_dout}, 70'(0));
    chk("rst_alu_idle", {alu_op, alu_din1, alu_din2}, 68'(0));

    // Single request: ADD 5+7, accepted immediately, drained next cycle
    @(negedge clk);
    a_req_valid = 1; a_op = OP_ADD; a_din1 = 5; a_din2 = 7; a_resp_ready = 1;
    #1;
    chk("single_ready", {a_req_ready, b_req_ready}, 64'(2'b10));
    @(negedge clk);
    a_req_valid = 0;
    #1;
    chk("single_resp", {a_resp_valid, a_dout}, {1'b1, 32'd12});
    @(negedge clk);
    #1;
    chk("single_drained", {a_resp_valid, a_dout}, {1'b0, 32'd12});

    // Reset while a result is pending
    @(negedge clk);
    a_req_valid = 1; a_op = OP_ADD; a_din1 = 20; a_din2 = 22; a_resp_ready = 0;
    @(negedge clk);
    a_req_valid = 0;
    #1;
    chk("pending_resp", {a_resp_valid, a_dout}, {1'b1, 32'd42});
    rst = 1'b0;
    #1;
    chk("midop_rst", {a_resp_valid, a_dout, a_comp}, 64'(0));
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;

    a_dir.push_back('{OP_ADD, 32'd1, 32'd2});
    a_dir.push_back('{OP_ADD, 32'd100, 32'd23});
    a_dir.push_back('{OP_ADD, 32'hffff_ffff, 32'd1});
    a_dir.push_back('{OP_ADD, 32'd7, 32'd8});
    a_dir.push_back('{OP_ADD, 32'd0, 32'd0});
    a_dir.push_back('{OP_SLT, 32'hffff_ffff, 32'd1});
    b_dir.push_back('{OP_SUB, 32'd10, 32'd3});

    step(1, 1, 1, 1);                         // pointer=A after reset: A wins
    step(0, 1, 1, 1);
    repeat (3) step(0, 0, 1, 1);              // idle: NOP, pointer held
    repeat (4) step(1, 0, 1, 1);              // A streaming
    repeat (6) step(1, 1, 1, 1);              // contention incl. SLT -1<1
    repeat (6) step(1, 1, 0, 1);              // A back-pressured, B streams
    repeat (3) step(1, 1, 1, 1);
    repeat (500) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    repeat (4) step(0, 0, 1, 1);
    @(negedge clk);
    #2;
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
